// File: rtl/csla_seq_ctrl_pkg.sv
// Shared definitions for the sequential carry-select add/subtract controller:
// slice width, controller states and the slice-count helper.
package csla_seq_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/csla_seq_ctrl_csla.sv
// 4-bit carry-select adder: 2-bit ripple low half, upper half precomputed
// for both carry values and selected by the low-half carry.
module csla
    import csla_seq_ctrl_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [2:0] w_lo;
    logic [2:0] w_hi0;
    logic [2:0] w_hi1;

    assign w_lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    assign w_hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign w_hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;

    always_comb begin
        s    = 4'd0;
        cout = 1'b0;
        if (w_lo[2]) begin
            s    = {w_hi1[1:0], w_lo[1:0]};
            cout = w_hi1[2];
        end else begin
            s    = {w_hi0[1:0], w_lo[1:0]};
            cout = w_hi0[2];
        end
    end

endmodule

// File: rtl/csla_seq_ctrl.sv
// WIDTH-bit add/subtract built by stepping one shared 4-bit carry-select
// slice over the operands, LSB slice first, with the slice carry registered.
module csla_seq_ctrl
    import csla_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    // WIDTH is expected to be a non-zero multiple of SLICE_W.
    localparam int NSLICE = slice_count(WIDTH);
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends combinationally on ready on either side.
    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_op_a;
    logic [WIDTH-1:0]  r_op_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic [IDXW-1:0]   r_idx;

    logic [SLICE_W-1:0] w_slice_a;
    logic [SLICE_W-1:0] w_slice_b;
    logic [SLICE_W-1:0] w_slice_s;
    logic               w_slice_cout;
    logic               w_last;
    logic               w_accept;
    logic               w_release;

    assign w_last    = (r_idx == IDXW'(NSLICE - 1));
    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_release = (r_state == ST_DONE) && out_ready;

    always_comb begin
        w_slice_a = '0;
        w_slice_b = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_slice_a = r_op_a[k*SLICE_W +: SLICE_W];
                w_slice_b = r_op_b[k*SLICE_W +: SLICE_W];
            end
        end
    end

    csla u_csla (
        .a    (w_slice_a),
        .b    (w_slice_b),
        .cin  (r_carry),
        .s    (w_slice_s),
        .cout (w_slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (w_release) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Subtraction runs as a + ~b + !cin, so the final carry reads as "no borrow".
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_a  <= a;
                        r_op_b  <= sub ? ~b : b;
                        r_carry <= sub ? ~cin : cin;
                        r_sum   <= '0;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < NSLICE; k++) begin
                        if (r_idx == IDXW'(k)) begin
                            r_sum[k*SLICE_W +: SLICE_W] <= w_slice_s;
                        end
                    end
                    r_carry <= w_slice_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout <= w_slice_cout;
                        r_ovf  <= (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                                  (w_slice_s[SLICE_W-1] != r_op_a[WIDTH-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
